// File: rtl/mul_pkg.sv
// mul_pkg: state encoding, default widths and the round-robin grant search shared
// by the multiplier sequencer and its datapath.
package mul_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int MAX_REQ     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // First set bit of valid strictly after last, wrapping at n; -1 when none is set.
    function automatic int rr_next(input logic [MAX_REQ-1:0] valid, input int last, input int n);
        int pick;
        int idx;
        pick = -1;
        idx  = 0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n && pick < 0) begin
                idx = last + i;
                if (idx >= n) idx = idx - n;
                if (valid[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// mul_shift_add_core: one-bit-per-cycle unsigned shift-add multiplier datapath.
// With MUL_EARLY_TERM_EN defined, done also fires once the remaining multiplier bits are zero.
module mul_shift_add_core
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    output logic               done,
    output logic [2*WIDTH-1:0] acc_next
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

`ifdef MUL_EARLY_TERM_EN
    // The step in progress consumes mplier[0]; nothing above it means no further adds.
    assign done = (count == LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign done = (count == LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, in0};
            acc    <= '0;
            mplier <= in1;
            count  <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mul_rr_sequencer.sv
// mul_rr_sequencer: round-robin front end sharing one shift-add multiplier among
// NUM_REQ requesters; MUL_EARLY_TERM_EN selects the early-terminating datapath.
module mul_rr_sequencer
    import mul_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy,
    output state_t                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a requester holds valid and operands until then, and the response holds
    // rsp_id/rsp_result until rsp_ready.

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    int                 grant_idx;
    logic               any_valid;
    logic [ID_W-1:0]    grant;
    logic [WIDTH-1:0]   sel_in0;
    logic [WIDTH-1:0]   sel_in1;
    logic               core_load;
    logic               core_step;
    logic               core_done;
    logic [2*WIDTH-1:0] core_acc_next;

    assign grant_idx = rr_next(MAX_REQ'(req_valid), int'(last_grant), NUM_REQ);
    assign any_valid = (grant_idx >= 0);
    assign grant     = any_valid ? ID_W'(grant_idx) : '0;
    assign sel_in0   = req_in0[grant*WIDTH +: WIDTH];
    assign sel_in1   = req_in1[grant*WIDTH +: WIDTH];

    assign req_ready = (state == IDLE && rst && any_valid) ? (NUM_REQ'(1) << grant) : '0;
    assign core_load = (state == IDLE) && any_valid;
    assign core_step = (state == RUN);
    assign dbg_state = state;

    mul_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .in0      (sel_in0),
        .in1      (sel_in1),
        .done     (core_done),
        .acc_next (core_acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Capture the sum including this cycle's final add.
                    if (core_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= last_grant;
                        rsp_result <= core_acc_next;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_rr_sequencer.md
# mul_rr_sequencer

- Shares one iterative shift-add multiplier between NUM_REQ requesters, each with a valid/ready interface.
- Grants are round-robin; one operation is in flight at a time.
- Each result is returned on a single response channel, tagged with the requester id.
- Sits between the issuing units and the multiplier datapath; it replaces per-requester combinational multipliers in the 32-bit build.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH.
- NUM_REQ, 4, number of requesters (>=2); ID_W = $clog2(NUM_REQ) is derived, not overridable.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high.
- req_in0  in  NUM_REQ*WIDTH  multiplicands; requester i at [i*WIDTH +: WIDTH].
- req_in1  in  NUM_REQ*WIDTH  multipliers, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_result  out  2*WIDTH  unsigned product in0*in1.
- busy  out  1  high in RUN and RESP.

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE**
  - If any req_valid is high, the grant goes to the first valid requester searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[grant] is high combinationally in that cycle.
  - On the clock edge: latch in0 into the multiplicand register and in1 into the multiplier register; latch the id; clear the accumulator; set count=0; update last_grant; go to RUN.
- **RUN**, one bit per cycle:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 (2*WIDTH wide) and the multiplier right by 1; increment count.
  - After the cycle with count==WIDTH-1, go to RESP.
- **RESP**
  - rsp_valid=1; rsp_id and rsp_result are held stable until rsp_ready=1.
  - On the handshake edge, go to IDLE.
  - No request is accepted in RESP.
- Arithmetic:
  - Unsigned only, full 2*WIDTH product, no truncation or overflow.
  - The accumulator is 2*WIDTH bits and cannot wrap.
- Requester protocol: req_valid and operands must be held stable until req_ready. Withdrawing req_valid before the grant is legal; the arbiter simply skips that requester.
- req_ready is 0 outside IDLE and 0 whenever rst is low.

## Timing
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
- Latency:
  - Accept cycle is A. rsp_valid is first high in cycle A+WIDTH+1.
  - Minimum spacing between accepts is WIDTH+2 cycles, reached with rsp_ready tied high.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid high and are served in later passes in round-robin order.
- A reset assertion in RUN or RESP clears all state immediately. The in-flight operation is discarded and no response is produced after release.
- rsp_ready while rsp_valid=0 is ignored.

## Configuration
- MUL_EARLY_TERM_EN
  - **Defined:** RUN exits after the cycle in which the shifted multiplier becomes zero, or at count==WIDTH-1, whichever comes first.
    - If h is the highest set bit of in1, rsp_valid is first high at A+h+2.
    - If in1==0, rsp_valid is first high at A+2.
  - **Undefined:** fixed latency of WIDTH RUN cycles, as above.
- Results are identical in both builds.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE/RUN/RESP);
  - the default-width localparams;
  - a function for the round-robin next-grant search.
- Sub-module mul_shift_add_core contains the datapath: operand registers, accumulator, count, and the load/step/done handshake.
- mul_rr_sequencer keeps the FSM, the arbiter and the response register.

## Test plan
All scenarios use WIDTH=4, NUM_REQ=4.
- Requester 0 only, in0=2, in1=3 -> rsp_id=0, rsp_result=6, rsp_valid first high at A+5.
- All four valid at once with (5,3), (7,2), (4,4), (15,1) -> grants in order 0,1,2,3; results 15, 14, 16, 15 with matching rsp_id; accepts spaced 6 cycles apart with rsp_ready=1.
- Boundary operands (0,5) and (15,15) -> results 0 and 225; rsp_result is never truncated.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_result are stable; no req_ready pulse occurs while busy=1.
- rst driven low at RUN count=2 -> all outputs 0 immediately; no rsp_valid after release; the next grant goes to requester 0.
- MUL_EARLY_TERM_EN defined:
  - in1=1 -> rsp_valid at A+2.
  - in1=0 -> rsp_valid at A+2, result 0.
  - in1=8 -> rsp_valid at A+5, and in0=3 gives 24.
